// File: rtl/recip_div_pkg.sv
// Shared types and width helpers for the reciprocal-based divider.
package recip_div_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RELEASE = 3'd2,
    MUL     = 3'd3,
    DONE    = 3'd4
  } div_state_t;

  // Product of an N-bit dividend and a 2N-bit reciprocal.
  function automatic int prod_w(input int n);
    return 3 * n;
  endfunction

  // Bit counter for 2N multiplier steps, with one spare bit.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/recip_divider_mul.sv
// Sequential shift-add multiplier: acc += bit ? (a << i) : 0, one bit per step.
// RECIP_DIV_ROUND_EN selects a round-half-up preload instead of zero.
module shift_add_mul
  import recip_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         op_bit,
  input  logic [N-1:0] a,
  output logic         last,
  output logic [N:0]   hi
);

  localparam int PW = prod_w(N);
  localparam int CW = cnt_w(N);

`ifdef RECIP_DIV_ROUND_EN
  localparam logic [PW-1:0] PRELOAD = PW'(1) << (2 * N - 1);
`else
  localparam logic [PW-1:0] PRELOAD = '0;
`endif

  logic [PW-1:0] acc;
  logic [PW-1:0] addend;
  logic [PW:0]   sum;
  logic [CW-1:0] cnt;

  assign addend = op_bit ? (PW'(a) << cnt) : '0;
  assign sum    = {1'b0, acc} + {1'b0, addend};
  // Integer part of the post-step sum, with carry kept for saturation.
  assign hi     = sum[PW:2*N];
  assign last   = (cnt == CW'(2 * N - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= PRELOAD;
      cnt <= '0;
    end else if (step) begin
      acc <= sum[PW-1:0];
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/recip_divider.sv
// Divider q = a / b: fetches x_inv ~ 2^2N/b over a 4-phase req/ack handshake,
// then q = (a * x_inv) >> 2N. Rounding is enabled by RECIP_DIV_ROUND_EN.
module recip_divider
  import recip_div_pkg::*;
#(
  parameter int N      = 8,
  parameter int N_ITER = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   q,
  output logic           done,
  output logic           busy,
  output logic           dz,
  output logic           inv_req,
  output logic [N-1:0]   inv_x,
  output logic [3:0]     n_iter,
  input  logic           inv_ack,
  input  logic [2*N-1:0] x_inv,
  output div_state_t     state_dbg
);

  // Handshake: inv_req rises in REQ and stays high until inv_ack is seen high;
  // the transfer completes only after inv_ack returns low (RELEASE).

  div_state_t     state, next_state;
  logic [N-1:0]   a_r, b_r;
  logic [2*N-1:0] x_r;
  logic           x_load, mul_load, mul_step, mul_last;
  logic [N:0]     mul_hi;

  assign inv_x     = b_r;
  assign n_iter    = 4'(N_ITER);
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    x_load     = 1'b0;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // x_inv cannot represent 1.0, so b==1 bypasses the reciprocal unit.
          if (b == '0 || b == N'(1)) next_state = DONE;
          else                       next_state = REQ;
        end
      end
      REQ: begin
        if (inv_ack) begin
          x_load     = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!inv_ack) begin
          mul_load   = 1'b1;
          next_state = MUL;
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      x_r     <= '0;
      q       <= '0;
      dz      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      inv_req <= 1'b0;
    end else begin
      state   <= next_state;
      done    <= (next_state == DONE);
      busy    <= (next_state != IDLE);
      inv_req <= (next_state == REQ);
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
        if (b == '0) begin
          q  <= '1;
          dz <= 1'b1;
        end else if (b == N'(1)) begin
          q  <= a;
          dz <= 1'b0;
        end
      end
      if (x_load)        x_r <= x_inv;
      else if (mul_step) x_r <= x_r >> 1;
      if (mul_step && mul_last) begin
        dz <= 1'b0;
        q  <= mul_hi[N] ? '1 : mul_hi[N-1:0];
      end
    end
  end

  shift_add_mul #(.N(N)) u_mul (
    .clock  (clock),
    .reset  (reset),
    .load   (mul_load),
    .step   (mul_step),
    .op_bit (x_r[0]),
    .a      (a_r),
    .last   (mul_last),
    .hi     (mul_hi)
  );

endmodule

// File: tb/tb_recip_divider.sv
// Self-checking bench for recip_divider (N=8) with a synchronous reciprocal-unit model.
module tb_recip_divider;
  import recip_div_pkg::*;

  localparam int N = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0, b = '0;
  logic [N-1:0]   q, inv_x;
  logic           done, busy, dz, inv_req;
  logic [3:0]     n_iter;
  logic           inv_ack = 1'b0;
  logic [2*N-1:0] x_inv = '0;
  div_state_t     state_dbg;

  int checks = 0;
  int errors = 0;
  int lat_l  = 3;
  int hold   = 0;
  int rcnt   = 0;
  int hcnt   = 0;

  recip_divider #(.N(N), .N_ITER(3)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .q(q),
    .done(done), .busy(busy), .dz(dz), .inv_req(inv_req), .inv_x(inv_x),
    .n_iter(n_iter), .inv_ack(inv_ack), .x_inv(x_inv), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Reciprocal unit: raises ack lat_l clocks after seeing req, returns
  // floor(2^16 / x), and drops ack hold clocks after req falls.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      inv_ack <= 1'b0;
      rcnt    <= 0;
      hcnt    <= 0;
    end else if (!inv_ack) begin
      hcnt <= 0;
      if (inv_req) begin
        if (rcnt >= lat_l - 1) begin
          inv_ack <= 1'b1;
          x_inv   <= (inv_x == '0) ? 16'd0 : 16'(32'h10000 / int'(inv_x));
          rcnt    <= 0;
        end else begin
          rcnt <= rcnt + 1;
        end
      end else begin
        rcnt <= 0;
      end
    end else if (!inv_req) begin
      if (hcnt >= hold) inv_ack <= 1'b0;
      else              hcnt <= hcnt + 1;
    end
  end

  function automatic logic [N-1:0] ref_q(input int av, input int bv);
    int x, p, r;
    if (bv == 0) return 8'hFF;
    if (bv == 1) return 8'(av);
    x = 65536 / bv;
    p = av * x;
`ifdef RECIP_DIV_ROUND_EN
    p = p + 32768;
`endif
    r = p >> 16;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  function automatic int ref_lat(input int bv, input int l, input int h);
    if (bv < 2) return 2;
    return l + 2 * N + 5 + h;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  // Start one division and wait (bounded) for done; latency counts the
  // start-sampling edge as clock 1 and the edge after done as the last.
  task automatic do_div(input logic [N-1:0] av, input logic [N-1:0] bv,
                        output logic [N-1:0] qv, output logic dzv,
                        output int lat, output bit req_seen, output logic done_after);
    @(negedge clock);
    a = av; b = bv; start = 1'b1;
    req_seen = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (inv_req) req_seen = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    lat = lat + 1;
    qv  = q;
    dzv = dz;
    @(posedge clock); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (q !== '0)          begin errors++; $display("FAIL reset_q got %0d want 0", q); end
    if (dz !== 1'b0)       begin errors++; $display("FAIL reset_dz got %b want 0", dz); end
    if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (inv_req !== 1'b0)  begin errors++; $display("FAIL reset_inv_req got %b want 0", inv_req); end
    if (inv_x !== '0)      begin errors++; $display("FAIL reset_inv_x got %0d want 0", inv_x); end
    if (n_iter !== 4'd3)   begin errors++; $display("FAIL n_iter got %0d want 3", n_iter); end
  endtask

  task automatic test_vector();
    logic [N-1:0] qv; logic dzv, da; int lat; bit rs;
    logic [N-1:0] exp_q;
`ifdef RECIP_DIV_ROUND_EN
    exp_q = 8'd20;
`else
    exp_q = 8'd19;
`endif
    lat_l = 3; hold = 0;
    do_div(8'd200, 8'd10, qv, dzv, lat, rs, da);
    checks += 5;
    if (qv !== exp_q)   begin errors++; $display("FAIL vec_q got %0d want %0d", qv, exp_q); end
    if (dzv !== 1'b0)   begin errors++; $display("FAIL vec_dz got %b want 0", dzv); end
    if (lat != 24)      begin errors++; $display("FAIL vec_latency got %0d want 24", lat); end
    if (rs !== 1'b1)    begin errors++; $display("FAIL vec_req got %b want 1", rs); end
    if (da !== 1'b0)    begin errors++; $display("FAIL vec_done_pulse got %b want 0", da); end
  endtask

  task automatic test_special_divisors();
    logic [N-1:0] qv; logic dzv, da; int lat; bit rs;
    do_div(8'd77, 8'd0, qv, dzv, lat, rs, da);
    checks += 4;
    if (qv !== 8'd255)  begin errors++; $display("FAIL dz_q got %0d want 255", qv); end
    if (dzv !== 1'b1)   begin errors++; $display("FAIL dz_flag got %b want 1", dzv); end
    if (lat != 2)       begin errors++; $display("FAIL dz_latency got %0d want 2", lat); end
    if (rs !== 1'b0)    begin errors++; $display("FAIL dz_req got %b want 0", rs); end
    do_div(8'd123, 8'd1, qv, dzv, lat, rs, da);
    checks += 4;
    if (qv !== 8'd123)  begin errors++; $display("FAIL one_q got %0d want 123", qv); end
    if (dzv !== 1'b0)   begin errors++; $display("FAIL one_dz got %b want 0", dzv); end
    if (lat != 2)       begin errors++; $display("FAIL one_latency got %0d want 2", lat); end
    if (rs !== 1'b0)    begin errors++; $display("FAIL one_req got %b want 0", rs); end
  endtask

  task automatic test_slow_ack();
    logic [N-1:0] qv, av, bv; logic dzv, da; int lat; bit rs;
    av = 8'($urandom_range(0, 255));
    bv = 8'($urandom_range(2, 255));
    lat_l = 2; hold = 10;
    do_div(av, bv, qv, dzv, lat, rs, da);
    checks += 2;
    if (qv !== ref_q(av, bv)) begin errors++; $display("FAIL slow_q a=%0d b=%0d got %0d want %0d", av, bv, qv, ref_q(av, bv)); end
    if (lat != ref_lat(bv, 2, 10)) begin errors++; $display("FAIL slow_latency got %0d want %0d", lat, ref_lat(bv, 2, 10)); end
    hold = 0;
  endtask

  task automatic test_start_during_mul();
    logic [N-1:0] av, bv, exp_q; int cyc;
    av = 8'($urandom_range(0, 255));
    bv = 8'($urandom_range(2, 255));
    exp_q = ref_q(av, bv);
    lat_l = 1;
    @(negedge clock);
    a = av; b = bv; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (state_dbg != MUL && cyc < 50) begin @(negedge clock); cyc++; end
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clock); cyc++; end
    // Start presented in the done cycle must also be ignored.
    start = 1'b1;
    checks += 3;
    if (done !== 1'b1)  begin errors++; $display("FAIL mid_start_done got %b want 1", done); end
    if (q !== exp_q)    begin errors++; $display("FAIL mid_start_q got %0d want %0d", q, exp_q); end
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    if (busy !== 1'b0)  begin errors++; $display("FAIL done_start_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_mul();
    logic [N-1:0] qv; logic dzv, da; int lat, cyc; bit rs;
    lat_l = 2;
    @(negedge clock);
    a = 8'd250; b = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (state_dbg != MUL && cyc < 50) begin @(negedge clock); cyc++; end
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    checks += 5;
    if (q !== '0)         begin errors++; $display("FAIL rst_mid_q got %0d want 0", q); end
    if (dz !== 1'b0)      begin errors++; $display("FAIL rst_mid_dz got %b want 0", dz); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
    if (inv_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b want 0", inv_req); end
    @(posedge clock); #1 reset = 1'b0;
    do_div(8'd100, 8'd7, qv, dzv, lat, rs, da);
    checks += 1;
    if (qv !== 8'd14)     begin errors++; $display("FAIL after_rst_q got %0d want 14", qv); end
  endtask

  task automatic test_random();
    logic [N-1:0] qv, av, bv, exp_q[$]; logic dzv, da; int lat, l; bit rs;
    for (int i = 0; i < 20; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = (i < 2) ? 8'(i) : 8'($urandom_range(0, 255));
      l  = $urandom_range(1, 4);
      lat_l = l;
      exp_q.push_back(ref_q(av, bv));
      do_div(av, bv, qv, dzv, lat, rs, da);
      checks += 4;
      if (qv !== exp_q[0]) begin errors++; $display("FAIL rand_q a=%0d b=%0d got %0d want %0d", av, bv, qv, exp_q[0]); end
      if (dzv !== (bv == 0)) begin errors++; $display("FAIL rand_dz b=%0d got %b want %b", bv, dzv, bv == 0); end
      if (lat != ref_lat(bv, l, 0)) begin errors++; $display("FAIL rand_latency b=%0d L=%0d got %0d want %0d", bv, l, lat, ref_lat(bv, l, 0)); end
      if (rs !== (bv > 1)) begin errors++; $display("FAIL rand_req b=%0d got %b want %b", bv, rs, bv > 1); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_special_divisors();
    test_slow_ack();
    test_start_during_mul();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
